// File: rtl/draw_scheduler_if.sv
// ---------------------------------------------------------------------------
// draw_scheduler_if
//   Bundles the per-frame control/handshake signals between the game logic,
//   the sprite plotter datapath and the draw scheduler.
//   master : the scheduler (drives grant/busy/frame_tick/frame_count/flags)
//   slave  : game logic + datapath (drive enable/req/plot_done/clear_err)
//   Signals:
//     enable      frame timer run
//     req         level redraw requests, one bit per sprite layer
//     plot_done   one-cycle pulse: current sprite fully plotted
//     clear_err   synchronous clear of the sticky error flags
//     grant       one-hot (or zero) draw select
//     busy        scheduler has an active draw or pending requests
//     frame_tick  one-cycle frame boundary pulse
//     frame_count frames elapsed (wraps)
//     overrun     sticky: frame tick arrived during a draw
//     timeout_err sticky: a draw never reported plot_done
// ---------------------------------------------------------------------------
interface draw_scheduler_if #(
  parameter int NUM_REQ = 8
);
  logic               enable;
  logic [NUM_REQ-1:0] req;
  logic               plot_done;
  logic               clear_err;
  logic [NUM_REQ-1:0] grant;
  logic               busy;
  logic               frame_tick;
  logic [7:0]         frame_count;
  logic               overrun;
  logic               timeout_err;

  modport master (
    input  enable, req, plot_done, clear_err,
    output grant, busy, frame_tick, frame_count, overrun, timeout_err
  );

  modport slave (
    output enable, req, plot_done, clear_err,
    input  grant, busy, frame_tick, frame_count, overrun, timeout_err
  );
endinterface

// File: rtl/draw_scheduler.sv
// ---------------------------------------------------------------------------
// draw_scheduler
//   Per-frame sequencer for the shared sprite plotter / VGA write port.
//   Generates the frame tick, latches redraw requests on each tick and hands
//   the plotter one layer at a time in fixed priority (bit 0 first),
//   advancing on plot_done, with a watchdog per draw.
//   Ports:
//     clk     system clock
//     resetn  asynchronous active-low reset
//     bus     draw_scheduler_if.master (see interface for signal list)
// ---------------------------------------------------------------------------
module draw_scheduler #(
  parameter int NUM_REQ          = 8,
  parameter int FRAME_CYCLES     = 833334,
  parameter int CNT_WIDTH        = 20,
  parameter int MAX_GRANT_CYCLES = 131072
) (
  input  logic             clk,
  input  logic             resetn,
  draw_scheduler_if.master bus
);

  localparam int WD_WIDTH = $clog2(MAX_GRANT_CYCLES + 1);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(FRAME_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [WD_WIDTH-1:0]  WD_LAST  = WD_WIDTH'(MAX_GRANT_CYCLES - 1);
  localparam logic [WD_WIDTH-1:0]  WD_ONE   = WD_WIDTH'(1);
  localparam logic [NUM_REQ-1:0]   REQ_ONE  = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t               state_r, state_next_s;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 tick_r;
  logic [7:0]           fcount_r;
  logic [NUM_REQ-1:0]   pending_r, pending_next_s;
  logic [NUM_REQ-1:0]   pick_mask_s;
  logic [NUM_REQ-1:0]   grant_r, grant_next_s;
  logic [WD_WIDTH-1:0]  wdog_r, wdog_next_s;
  logic                 timeout_set_s;
  logic                 overrun_set_s;
  logic                 overrun_r, timeout_r;

  // Isolates the lowest set bit: x & -x (two's complement).
  function automatic logic [NUM_REQ-1:0] lowest_set(input logic [NUM_REQ-1:0] vec);
    return vec & (~vec + REQ_ONE);
  endfunction

  // Frame timer: counts while enabled, wraps at the frame length and pulses the tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (!bus.enable) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r  <= '0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + CNT_ONE;
      tick_r <= 1'b0;
    end
  end

  // Frame counter: advances once per frame tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fcount_r <= 8'd0;
    end else if (tick_r) begin
      fcount_r <= fcount_r + 8'd1;
    end else begin
      fcount_r <= fcount_r;
    end
  end

  // Next-state, grant select, watchdog and pending-request update.
  always_comb begin
    state_next_s  = state_r;
    grant_next_s  = grant_r;
    wdog_next_s   = wdog_r;
    pick_mask_s   = '0;
    timeout_set_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        grant_next_s = '0;
        if (pending_r != '0) begin
          pick_mask_s  = lowest_set(pending_r);
          grant_next_s = lowest_set(pending_r);
          wdog_next_s  = '0;
          state_next_s = S_GRANT;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_GRANT: begin
        if (bus.plot_done) begin
          grant_next_s = '0;
          state_next_s = S_GAP;
        end else if (wdog_r == WD_LAST) begin
          // The increment would reach the limit: abandon this draw.
          grant_next_s  = '0;
          wdog_next_s   = '0;
          timeout_set_s = 1'b1;
          state_next_s  = S_GAP;
        end else begin
          wdog_next_s = wdog_r + WD_ONE;
        end
      end
      S_GAP: begin
        // One dead cycle so the plotter's done/enable can drop before the next grant.
        grant_next_s = '0;
        state_next_s = S_IDLE;
      end
      default: begin
        grant_next_s = '0;
        state_next_s = S_IDLE;
      end
    endcase
    // A bit re-requested on the tick that picks it stays pending for another draw.
    pending_next_s = (pending_r & ~pick_mask_s) | (tick_r ? bus.req : '0);
    overrun_set_s  = tick_r && ((state_r == S_GRANT) || (state_r == S_GAP));
  end

  // Scheduler state, grant, watchdog and pending registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= S_IDLE;
      grant_r   <= '0;
      wdog_r    <= '0;
      pending_r <= '0;
    end else begin
      state_r   <= state_next_s;
      grant_r   <= grant_next_s;
      wdog_r    <= wdog_next_s;
      pending_r <= pending_next_s;
    end
  end

  // Sticky error flags: setting wins over a simultaneous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      if (overrun_set_s) begin
        overrun_r <= 1'b1;
      end else if (bus.clear_err) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
      if (timeout_set_s) begin
        timeout_r <= 1'b1;
      end else if (bus.clear_err) begin
        timeout_r <= 1'b0;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end

  assign bus.grant       = grant_r;
  assign bus.busy        = (state_r != S_IDLE) || (pending_r != '0);
  assign bus.frame_tick  = tick_r;
  assign bus.frame_count = fcount_r;
  assign bus.overrun     = overrun_r;
  assign bus.timeout_err = timeout_r;

endmodule

// File: tb/tb_draw_scheduler.sv
// ---------------------------------------------------------------------------
// tb_draw_scheduler
//   Scoreboard bench for draw_scheduler (FRAME_CYCLES=16, MAX_GRANT_CYCLES=40).
//   A stimulus process drives inputs each cycle and advances a behavioural
//   model (current draw index, draw age, post-draw dead cycle, pending set,
//   cycles into the frame). Expected per-cycle outputs and the expected order
//   of grants are queued; a monitor process pops and compares them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_draw_scheduler;
  localparam int NR = 8;
  localparam int FC = 16;
  localparam int MG = 40;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  draw_scheduler_if #(.NUM_REQ(NR)) bus ();

  draw_scheduler #(
    .NUM_REQ(NR), .FRAME_CYCLES(FC), .CNT_WIDTH(5), .MAX_GRANT_CYCLES(MG)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  typedef struct packed {
    logic [7:0] grant;
    logic       busy;
    logic       tick;
    logic [7:0] fc;
    logic       ovr;
    logic       to;
  } rec_t;

  rec_t       exp_q[$];
  logic [7:0] order_q[$];
  int total = 0;
  int bad = 0;
  int rise_b0 = 0;

  // Behavioural model state (values currently visible on the outputs).
  int         m_cur;   // index being drawn, -1 when none
  int         m_age;   // cycles the current draw has been granted
  int         m_cnt;   // cycles into the current frame
  bit         m_gap;   // first dead cycle after a draw ended
  bit         m_tick, m_ovr, m_to, last_pick;
  logic [7:0] m_pend;
  logic [7:0] m_fc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    if (last_pick) void'(order_q.pop_back());
    last_pick = 1'b0;
    m_cur = -1; m_age = 0; m_cnt = 0; m_gap = 1'b0;
    m_tick = 1'b0; m_ovr = 1'b0; m_to = 1'b0;
    m_pend = 8'h00; m_fc = 8'h00;
  endtask

  task automatic step(input bit en, input bit rn, input logic [7:0] rq, input bit pd, input bit ce);
    rec_t r;
    int pick, n_cur, n_age, n_cnt;
    bit ended, tset, n_gap, n_tick, n_ovr, n_to;
    logic [7:0] n_pend, n_fc;
    bus.enable = en; bus.req = rq; bus.plot_done = pd; bus.clear_err = ce;
    resetn = rn;
    if (!rn) model_reset();
    r.grant = (m_cur >= 0) ? 8'(1 << m_cur) : 8'h00;
    r.busy  = (m_cur >= 0) || m_gap || (m_pend != 8'h00);
    r.tick  = m_tick; r.fc = m_fc; r.ovr = m_ovr; r.to = m_to;
    exp_q.push_back(r);
    last_pick = 1'b0;
    pick = -1;
    if (m_cur < 0 && !m_gap && m_pend != 8'h00)
      for (int i = NR - 1; i >= 0; i--) if (m_pend[i]) pick = i;
    n_pend = m_pend;
    if (pick >= 0) n_pend[pick] = 1'b0;
    if (m_tick) n_pend = n_pend | rq;
    ended = 1'b0; tset = 1'b0;
    if (m_cur >= 0) begin
      if (pd) ended = 1'b1;
      else if (m_age + 1 == MG) begin ended = 1'b1; tset = 1'b1; end
    end
    n_ovr = (m_tick && (m_cur >= 0 || m_gap)) ? 1'b1 : (ce ? 1'b0 : m_ovr);
    n_to  = tset ? 1'b1 : (ce ? 1'b0 : m_to);
    if (en && m_cnt == FC - 1) begin n_cnt = 0; n_tick = 1'b1; end
    else if (en) begin n_cnt = m_cnt + 1; n_tick = 1'b0; end
    else begin n_cnt = 0; n_tick = 1'b0; end
    n_fc = m_fc + {7'd0, m_tick};
    n_gap = ended;
    n_cur = m_cur; n_age = m_age + 1;
    if (pick >= 0) begin
      n_cur = pick; n_age = 0;
      order_q.push_back(8'(1 << pick));
      last_pick = 1'b1;
    end else if (ended) n_cur = -1;
    @(posedge clk); #1;
    if (rn) begin
      m_cur = n_cur; m_age = n_age; m_cnt = n_cnt; m_gap = n_gap; m_tick = n_tick;
      m_ovr = n_ovr; m_to = n_to; m_pend = n_pend; m_fc = n_fc;
    end
  endtask

  // mode 0: never done; 1: done 5 cycles into each draw; 2: directed overrun/retain;
  // 3: random everything.
  task automatic run(input int n, input bit en, input logic [7:0] rq, input int mode, input bit ce);
    bit pd, e, rn, c;
    logic [7:0] q;
    for (int k = 0; k < n; k++) begin
      e = en; q = rq; rn = 1'b1; c = ce;
      case (mode)
        1: pd = (m_cur >= 0) && (m_age == 5);
        2: pd = (m_cur == 1 && m_ovr && m_cnt == 14) || (m_cur == 0 && m_age == 3);
        3: begin
          pd = (m_cur >= 0) ? ($urandom_range(5) == 0) : ($urandom_range(15) == 0);
          e  = ($urandom_range(15) != 0);
          q  = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
          c  = ($urandom_range(63) == 0);
          rn = ($urandom_range(499) != 0);
        end
        default: pd = 1'b0;
      endcase
      step(e, rn, q, pd, c);
    end
  endtask

  // Monitor: compares every cycle's outputs and the order of grants against the queues.
  initial begin : monitor
    rec_t a, e;
    logic [7:0] prev_g, eg;
    prev_g = 8'h00;
    forever begin
      @(negedge clk);
      a.grant = bus.grant; a.busy = bus.busy; a.tick = bus.frame_tick;
      a.fc = bus.frame_count; a.ovr = bus.overrun; a.to = bus.timeout_err;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL cycle_outputs @%0t: actual g=%h busy=%b tick=%b fc=%0d ovr=%b to=%b required g=%h busy=%b tick=%b fc=%0d ovr=%b to=%b",
                   $time, a.grant, a.busy, a.tick, a.fc, a.ovr, a.to,
                   e.grant, e.busy, e.tick, e.fc, e.ovr, e.to);
        end
      end
      if (bus.grant != 8'h00 && prev_g == 8'h00) begin
        total++;
        if (bus.grant == 8'h01) rise_b0++;
        if (order_q.size() == 0) begin
          bad++;
          $display("FAIL grant_order @%0t: actual %h required no grant", $time, bus.grant);
        end else begin
          eg = order_q.pop_front();
          if (bus.grant !== eg) begin
            bad++;
            $display("FAIL grant_order @%0t: actual %h required %h", $time, bus.grant, eg);
          end
        end
      end
      total++;
      if ($countones(bus.grant) > 1) begin
        bad++;
        $display("FAIL grant_onehot @%0t: actual %h required at most one bit", $time, bus.grant);
      end
      prev_g = bus.grant;
    end
  end

  initial begin : stim
    int b0_before, guard;
    bus.enable = 1'b0; bus.req = 8'h00; bus.plot_done = 1'b0; bus.clear_err = 1'b0;
    last_pick = 1'b0;
    model_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {bus.grant, bus.busy, bus.frame_tick, bus.frame_count, bus.overrun, bus.timeout_err},
          32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Idle frames: ticks every 16 cycles, no grants.
    run(40, 1'b1, 8'h00, 0, 1'b0);
    check("frame_count_idle", bus.frame_count, 32'd2);

    // Three layers in one frame, plotted in priority order.
    run(16, 1'b1, 8'h85, 1, 1'b0);
    run(40, 1'b1, 8'h00, 1, 1'b0);
    check("busy_after_drain", bus.busy, 32'd0);

    // Plotter never answers: watchdog ends the draw.
    run(16, 1'b1, 8'h10, 0, 1'b0);
    run(50, 1'b1, 8'h00, 0, 1'b0);
    check("timeout_set", bus.timeout_err, 32'd1);
    run(1, 1'b1, 8'h00, 0, 1'b1);
    check("timeout_cleared", bus.timeout_err, 32'd0);
    check("overrun_cleared", bus.overrun, 32'd0);

    // Draw spans a tick (overrun), then bit 0 picked on a tick re-requesting it.
    b0_before = rise_b0;
    run(16, 1'b1, 8'h02, 2, 1'b0);
    run(32, 1'b1, 8'h01, 2, 1'b0);
    run(40, 1'b1, 8'h00, 2, 1'b0);
    check("overrun_set", bus.overrun, 32'd1);
    check("bit0_granted_twice", rise_b0 - b0_before, 32'd2);
    run(1, 1'b1, 8'h00, 0, 1'b1);

    // Reset in the middle of a draw.
    run(16, 1'b1, 8'h08, 0, 1'b0);
    guard = 0;
    while (m_cur < 0 && guard < 40) begin
      run(1, 1'b1, 8'h00, 0, 1'b0);
      guard++;
    end
    check("grant_before_reset", bus.grant, 32'h08);
    resetn = 1'b0;
    #1;
    check("reset_mid_grant",
          {bus.grant, bus.busy, bus.frame_tick, bus.frame_count, bus.overrun, bus.timeout_err},
          32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    run(12, 1'b1, 8'h00, 0, 1'b0);
    check("no_resume_after_reset", {bus.grant, bus.busy}, 32'd0);

    // Randomized traffic.
    run(1500, 1'b1, 8'h00, 3, 1'b0);

    // Drain with ticks stopped.
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    run(200, 1'b0, 8'h00, 1, 1'b0);
    @(negedge clk);
    #1;
    check("grant_queue_empty", order_q.size(), 32'd0);
    check("record_queue_empty", exp_q.size(), 32'd0);
    check("final_idle", bus.busy, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
